phase_sequencer: RTL

//  Round controller for per-node protocol task blocks (amISink-style: en/start/done handshake, private memory bus).

---
 rtl/phase_seq_pkg.sv | 24 ++
 rtl/mem_bus_mux.sv | 29 ++
 rtl/phase_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/phase_seq_pkg.sv
// rtl/phase_seq_pkg.sv - shared types, defaults and helpers for the phase sequencer
package phase_seq_pkg;

  localparam int WORD_WIDTH_DEF = 16;
  localparam int MAX_TASKS      = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ENABLE = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_NEXT   = 3'd4,
    ST_FINISH = 3'd5
  } phase_state_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [3:0] lowest_set(input logic [MAX_TASKS-1:0] v);
    lowest_set = 4'd0;
    for (int i = MAX_TASKS - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = i[3:0];
    end
  endfunction

endpackage

// File: rtl/mem_bus_mux.sv
// rtl/mem_bus_mux.sv - NUM_TASKS:1 memory bus mux, zero output unless grant is valid
module mem_bus_mux #(
  parameter int NUM_TASKS  = 4,
  parameter int WORD_WIDTH = 16
) (
  input  logic [NUM_TASKS*WORD_WIDTH-1:0] task_addr,
  input  logic [NUM_TASKS-1:0]            task_wr_en,
  input  logic [NUM_TASKS*WORD_WIDTH-1:0] task_wdata,
  input  logic [3:0]                      sel,
  input  logic                            grant,
  output logic [WORD_WIDTH-1:0]           mem_addr,
  output logic                            mem_wr_en,
  output logic [WORD_WIDTH-1:0]           mem_wdata
);

  always_comb begin
    mem_addr  = '0;
    mem_wr_en = 1'b0;
    mem_wdata = '0;
    for (int i = 0; i < NUM_TASKS; i++) begin
      if (grant && (sel == i[3:0])) begin
        mem_addr  = task_addr[i*WORD_WIDTH +: WORD_WIDTH];
        mem_wr_en = task_wr_en[i];
        mem_wdata = task_wdata[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - round controller running masked tasks in index order, shared memory grant
// Optional watchdog per task enabled by defining PHASE_TIMEOUT_EN.
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int NUM_TASKS      = 4,
  parameter int WORD_WIDTH     = WORD_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            clock,
  input  logic                            rst,
  input  logic                            run,
  input  logic [NUM_TASKS-1:0]            task_mask,
  input  logic [NUM_TASKS-1:0]            task_done,
  input  logic [NUM_TASKS*WORD_WIDTH-1:0] task_addr,
  input  logic [NUM_TASKS-1:0]            task_wr_en,
  input  logic [NUM_TASKS*WORD_WIDTH-1:0] task_wdata,
  output logic [NUM_TASKS-1:0]            task_en,
  output logic [NUM_TASKS-1:0]            task_start,
  output logic [WORD_WIDTH-1:0]           mem_addr,
  output logic                            mem_wr_en,
  output logic [WORD_WIDTH-1:0]           mem_wdata,
  output logic [3:0]                      task_idx,
  output logic                            busy,
  output logic                            round_done,
  output logic                            timeout_err
);

  phase_state_t          state;
  logic [NUM_TASKS-1:0]  pending;
  logic [NUM_TASKS-1:0]  idx_onehot;
  logic [NUM_TASKS-1:0]  remaining;
  logic                  cur_done;
  logic                  grant;
  logic                  wd_expired;

  assign idx_onehot = NUM_TASKS'(1) << task_idx;
  assign remaining  = pending & ~idx_onehot;
  assign cur_done   = |(task_done & idx_onehot);
  assign grant      = (state == ST_ENABLE) || (state == ST_START) || (state == ST_WAIT);

`ifdef PHASE_TIMEOUT_EN
  localparam logic [WORD_WIDTH-1:0] WD_LIMIT = WORD_WIDTH'(TIMEOUT_CYCLES - 1);
  logic [WORD_WIDTH-1:0] wd_cnt;

  assign wd_expired = (state == ST_WAIT) && !cur_done && (wd_cnt == WD_LIMIT);

  always_ff @(posedge clock) begin
    if (rst) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else if (state == ST_ENABLE) begin
      wd_cnt <= '0;
    end else if (state == ST_WAIT && !cur_done) begin
      if (wd_expired) timeout_err <= 1'b1;
      else            wd_cnt      <= wd_cnt + 1'b1;
    end
  end
`else
  assign wd_expired  = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (rst) begin
      state    <= ST_IDLE;
      pending  <= '0;
      task_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run) begin
            if (task_mask != '0) begin
              pending  <= task_mask;
              task_idx <= lowest_set(MAX_TASKS'(task_mask));
              state    <= ST_ENABLE;
            end else begin
              state <= ST_FINISH;
            end
          end
        end
        ST_ENABLE: state <= ST_START;
        ST_START:  state <= ST_WAIT;
        // done is only trusted here, so a level left over from a previous round is ignored
        ST_WAIT: begin
          if (cur_done || wd_expired) state <= ST_NEXT;
        end
        ST_NEXT: begin
          pending <= remaining;
          if (remaining != '0) begin
            task_idx <= lowest_set(MAX_TASKS'(remaining));
            state    <= ST_ENABLE;
          end else begin
            state <= ST_FINISH;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign task_en    = (state == ST_ENABLE) ? idx_onehot : '0;
  assign task_start = (state == ST_START)  ? idx_onehot : '0;
  assign busy       = (state != ST_IDLE);
  assign round_done = (state == ST_FINISH);

  mem_bus_mux #(
    .NUM_TASKS (NUM_TASKS),
    .WORD_WIDTH(WORD_WIDTH)
  ) u_mem_bus_mux (
    .task_addr (task_addr),
    .task_wr_en(task_wr_en),
    .task_wdata(task_wdata),
    .sel       (task_idx),
    .grant     (grant),
    .mem_addr  (mem_addr),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata)
  );

endmodule
